dcache_mem_bridge: RTL and testbench

DCACHE_MEM_BRIDGE -- requirements
Module: dcache_mem_bridge

---
 rtl/dcache_mem_bridge_pkg.sv | 21 ++
 rtl/dcache_mem_bridge.sv | 122 ++++++++++++
 tb/tb_dcache_mem_bridge.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcache_mem_bridge_pkg.sv
// Shared CPU/cache geometry and the bridge state encoding used by dcache_mem_bridge.
package dcache_mem_bridge_pkg;

  localparam int CPU_WORD            = 32;
  localparam int CACHE_LINE_WIDTH    = 128;
  localparam int CACHE_LINE_BYTE_LOG = $clog2(CACHE_LINE_WIDTH / 8);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RD_REQ  = 3'd1,
    ST_RD_WAIT = 3'd2,
    ST_WR_REQ  = 3'd3,
    ST_DONE    = 3'd4
  } bridge_state_e;

  // A one-word line still needs a 1-bit counter to keep vector widths legal.
  function automatic int beat_width(input int line_words);
    return (line_words > 1) ? $clog2(line_words) : 1;
  endfunction

endpackage

// File: rtl/dcache_mem_bridge.sv
// Bridges data-cache line refills and write-through stores onto a single-word
// request/grant memory port with in-order read data; one transaction at a time.
module dcache_mem_bridge
  import dcache_mem_bridge_pkg::*;
#(
  parameter int WORD       = CPU_WORD,
  parameter int LINE_WORDS = CACHE_LINE_WIDTH / CPU_WORD
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       req_valid,
  input  logic                       req_store,
  input  logic [WORD-1:0]            req_addr,
  input  logic [WORD-1:0]            req_wdata,
  output logic                       resp_ready,
  output logic [WORD*LINE_WORDS-1:0] resp_line,
  output logic                       mem_req,
  output logic                       mem_we,
  output logic [WORD-1:0]            mem_addr,
  output logic [WORD-1:0]            mem_wdata,
  input  logic                       mem_gnt,
  input  logic                       mem_rvalid,
  input  logic [WORD-1:0]            mem_rdata
);

  localparam int BEAT_W        = beat_width(LINE_WORDS);
  localparam int LINE_BYTE_LOG = $clog2(LINE_WORDS * 4);

  bridge_state_e     state_q, state_d;
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [WORD-1:0]   addr_q, addr_d;
  logic [WORD-1:0]   wdata_q, wdata_d;
  logic [WORD-1:0]   line_q [LINE_WORDS];
  logic [WORD-1:0]   line_base;
  logic              last_beat;
  logic              rd_accept;

  assign line_base = {addr_q[WORD-1:LINE_BYTE_LOG], {LINE_BYTE_LOG{1'b0}}};
  assign last_beat = (beat_q == BEAT_W'(LINE_WORDS - 1));
  // Read data only counts while a read beat is actually outstanding.
  assign rd_accept = (state_q == ST_RD_WAIT) && mem_rvalid;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      beat_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      beat_q  <= beat_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    resp_ready = 1'b0;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          addr_d  = req_addr;
          wdata_d = req_wdata;
          beat_d  = '0;
          state_d = req_store ? ST_WR_REQ : ST_RD_REQ;
        end
      end
      ST_RD_REQ: begin
        mem_req  = 1'b1;
        mem_addr = line_base + WORD'({beat_q, 2'b00});
        if (mem_gnt) state_d = ST_RD_WAIT;
      end
      ST_RD_WAIT: begin
        if (mem_rvalid) begin
          if (last_beat) begin
            state_d = ST_DONE;
          end else begin
            beat_d  = beat_q + BEAT_W'(1);
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_WR_REQ: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = {addr_q[WORD-1:2], 2'b00};
        mem_wdata = wdata_q;
        if (mem_gnt) state_d = ST_DONE;
      end
      ST_DONE: begin
        resp_ready = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Each line word is written only by its own beat, so the line holds between refills.
  for (genvar gi = 0; gi < LINE_WORDS; gi++) begin : g_line
    logic word_we;
    assign word_we = rd_accept && (beat_q == BEAT_W'(gi));

    always_ff @(posedge clk) begin
      if (rst) begin
        line_q[gi] <= '0;
      end else if (word_we) begin
        line_q[gi] <= mem_rdata;
      end
    end

    assign resp_line[gi*WORD +: WORD] = line_q[gi];
  end

endmodule

// File: tb/tb_dcache_mem_bridge.sv
// Randomised self-checking bench for dcache_mem_bridge against a word-memory model.
module tb_dcache_mem_bridge;

  logic         clk = 1'b0;
  logic         rst;
  logic         req_valid;
  logic         req_store;
  logic [31:0]  req_addr;
  logic [31:0]  req_wdata;
  logic         resp_ready;
  logic [127:0] resp_line;
  logic         mem_req;
  logic         mem_we;
  logic [31:0]  mem_addr;
  logic [31:0]  mem_wdata;
  logic         mem_gnt;
  logic         mem_rvalid;
  logic [31:0]  mem_rdata;

  int n_vec = 0;
  int n_err = 0;
  int resp_count = 0;

  logic [31:0]  mem_model [logic [31:0]];
  logic [127:0] exp_line;

  dcache_mem_bridge dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_store  (req_store),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_ready (resp_ready),
    .resp_line  (resp_line),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_gnt    (mem_gnt),
    .mem_rvalid (mem_rvalid),
    .mem_rdata  (mem_rdata)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (resp_ready === 1'b1) resp_count++;

  function automatic logic [31:0] mem_read(input logic [31:0] a);
    if (!mem_model.exists(a)) mem_model[a] = $urandom;
    return mem_model[a];
  endfunction

  // Runs one request against the memory model; entered and left at a negedge.
  task automatic run_txn(input bit store, input logic [31:0] addr, input logic [31:0] wdata,
                         input int gnt_delay, input int rv_lat, input bit spurious,
                         input bit wiggle, input int abort_beats, input string name);
    logic [31:0]  base;
    logic [31:0]  w [4];
    logic [127:0] line_before;
    logic [31:0]  want_addr;
    int beats, rx, wait_cnt, rv_cnt, cyc, exp_lat;
    bit done, pending, aborted;
    base = store ? {addr[31:2], 2'b00} : {addr[31:4], 4'h0};
    for (int k = 0; k < 4; k++) w[k] = store ? 32'h0 : mem_read(base + 32'(4 * k));
    line_before = exp_line;
    exp_lat = store ? 2 + gnt_delay : 4 * (1 + gnt_delay + rv_lat) + 1;
    beats = 0; rx = 0; wait_cnt = 0; rv_cnt = 0; cyc = 0;
    done = 0; aborted = 0;
    req_valid = 1'b1; req_store = store; req_addr = addr; req_wdata = wdata;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    while (!done && cyc < 300) begin
      @(negedge clk);
      cyc++;
      pending = (rv_cnt > 0);
      mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = $urandom;
      if (wiggle) req_valid = 1'($urandom_range(0, 1));
      if (rx == 0 || store) begin
        n_vec++;
        if (resp_line !== line_before) begin
          n_err++;
          $display("FAIL %s line_stable: cyc %0d got %h want %h", name, cyc, resp_line, line_before);
        end
      end
      if (resp_ready === 1'b1) begin
        n_vec++;
        if (cyc != exp_lat) begin
          n_err++;
          $display("FAIL %s latency: got %0d want %0d", name, cyc, exp_lat);
        end
        n_vec++;
        if ((store ? beats : rx) != (store ? 1 : 4)) begin
          n_err++;
          $display("FAIL %s beat_count: got %0d want %0d", name, store ? beats : rx, store ? 1 : 4);
        end
        if (!store) begin
          n_vec++;
          if (resp_line !== {w[3], w[2], w[1], w[0]}) begin
            n_err++;
            $display("FAIL %s resp_line: got %h want %h", name, resp_line, {w[3], w[2], w[1], w[0]});
          end
        end
        req_valid = 1'b0;
        done = 1;
      end else if (mem_req === 1'b1) begin
        want_addr = store ? base : base + 32'(4 * beats);
        n_vec++;
        if (pending || mem_we !== store || mem_addr !== want_addr) begin
          n_err++;
          $display("FAIL %s mem_req: outstanding %0d we %b/%b addr %h want %h",
                   name, pending, mem_we, store, mem_addr, want_addr);
        end
        if (store) begin
          n_vec++;
          if (mem_wdata !== wdata) begin
            n_err++;
            $display("FAIL %s mem_wdata: got %h want %h", name, mem_wdata, wdata);
          end
        end
        if (wait_cnt == gnt_delay) begin
          mem_gnt = 1'b1;
          wait_cnt = 0;
          beats++;
          if (store) mem_model[base] = wdata;
          else rv_cnt = rv_lat;
        end else begin
          wait_cnt++;
        end
      end
      if (pending) begin
        rv_cnt--;
        if (rv_cnt == 0) begin
          mem_rvalid = 1'b1;
          mem_rdata = (rx < 4) ? w[rx] : 32'h0;
          rx++;
        end
      end else if (spurious && mem_req === 1'b1 && !store) begin
        mem_rvalid = 1'b1;
        mem_rdata = 32'hBAD0_0000 | 32'(cyc);
      end
      if (abort_beats >= 0 && rx == abort_beats && rv_cnt > 0) begin
        rst = 1'b1;
        aborted = 1;
        done = 1;
      end
    end
    n_vec++;
    if (!done) begin
      n_err++;
      $display("FAIL %s timeout: no resp_ready after %0d cycles, want %0d", name, cyc, exp_lat);
      req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      exp_line = '0;
    end else if (!aborted) begin
      @(negedge clk);
      mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (!store) exp_line = {w[3], w[2], w[1], w[0]};
      if (resp_ready !== 1'b0 || mem_req !== 1'b0) begin
        n_err++;
        $display("FAIL %s single_pulse: resp_ready %b mem_req %b want 0 0", name, resp_ready, mem_req);
      end
      n_vec++;
      if (resp_line !== exp_line) begin
        n_err++;
        $display("FAIL %s line_hold: got %h want %h", name, resp_line, exp_line);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b1; req_store = 1'b0; req_addr = 32'h40; req_wdata = '0;
    mem_gnt = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'h1234_5678;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({resp_ready, mem_req, mem_we} !== 3'b000 || mem_addr !== 32'h0 || mem_wdata !== 32'h0
        || resp_line !== 128'h0) begin
      n_err++;
      $display("FAIL reset_outputs: rr %b req %b we %b addr %h wd %h line %h want all zero",
               resp_ready, mem_req, mem_we, mem_addr, mem_wdata, resp_line);
    end
    req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0; rst = 1'b0;
    @(negedge clk);
    n_vec++;
    if (mem_req !== 1'b0 || resp_ready !== 1'b0 || resp_line !== 128'h0) begin
      n_err++;
      $display("FAIL reset_release: req %b rr %b line %h want 0 0 0", mem_req, resp_ready, resp_line);
    end
    exp_line = '0;
  endtask

  task automatic test_refill_basic();
    mem_model[32'h1230] = 32'hA0;
    mem_model[32'h1234] = 32'hA1;
    mem_model[32'h1238] = 32'hA2;
    mem_model[32'h123C] = 32'hA3;
    run_txn(1'b0, 32'h0000_1234, 32'h0, 0, 1, 1'b0, 1'b0, -1, "refill_basic");
    n_vec++;
    if (resp_line !== 128'h000000A3_000000A2_000000A1_000000A0) begin
      n_err++;
      $display("FAIL refill_basic_line: got %h want 000000a3000000a2000000a1000000a0", resp_line);
    end
  endtask

  task automatic test_store_gnt_delay();
    run_txn(1'b1, 32'h0000_0106, 32'hDEADBEEF, 3, 1, 1'b0, 1'b0, -1, "store_delay");
    n_vec++;
    if (mem_model[32'h104] !== 32'hDEADBEEF) begin
      n_err++;
      $display("FAIL store_delay_write: got %h want deadbeef", mem_model[32'h104]);
    end
  endtask

  task automatic test_slow_spurious();
    run_txn(1'b0, 32'h0000_5A48, 32'h0, 1, 4, 1'b1, 1'b0, -1, "slow_spurious");
  endtask

  task automatic test_reset_mid();
    run_txn(1'b0, 32'h0000_3010, 32'h0, 0, 2, 1'b0, 1'b0, 2, "abort_refill");
    req_valid = 1'b0; mem_gnt = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({resp_ready, mem_req, mem_we} !== 3'b000 || mem_addr !== 32'h0 || mem_wdata !== 32'h0
        || resp_line !== 128'h0) begin
      n_err++;
      $display("FAIL abort_outputs: rr %b req %b we %b addr %h wd %h line %h want all zero",
               resp_ready, mem_req, mem_we, mem_addr, mem_wdata, resp_line);
    end
    rst = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFACE_0001;
    @(negedge clk);
    mem_rvalid = 1'b0;
    @(negedge clk);
    n_vec++;
    if (resp_line !== 128'h0 || mem_req !== 1'b0 || resp_ready !== 1'b0) begin
      n_err++;
      $display("FAIL abort_late_rvalid: line %h req %b rr %b want 0 0 0", resp_line, mem_req, resp_ready);
    end
    exp_line = '0;
    run_txn(1'b1, 32'h0000_3014, 32'h0BAD_CAFE, 0, 1, 1'b0, 1'b0, -1, "store_after_abort");
  endtask

  task automatic test_back_to_back();
    int cnt0;
    repeat (2) @(negedge clk);
    cnt0 = resp_count;
    run_txn(1'b0, 32'h0000_0104, 32'h0, 0, 1, 1'b0, 1'b0, -1, "b2b_refill");
    run_txn(1'b1, 32'h0000_0108, 32'h1357_9BDF, 0, 1, 1'b0, 1'b0, -1, "b2b_store");
    n_vec++;
    if (resp_count - cnt0 != 2) begin
      n_err++;
      $display("FAIL b2b_pulses: got %0d want 2", resp_count - cnt0);
    end
  endtask

  task automatic test_random();
    bit          st;
    logic [31:0] a;
    for (int t = 0; t < 24; t++) begin
      st = ($urandom_range(0, 2) == 0);
      a  = 32'h2000 + 32'($urandom_range(0, 255));
      run_txn(st, a, $urandom, int'($urandom_range(0, 3)), int'($urandom_range(1, 4)),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), -1, "random");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_store = 1'b0; req_addr = '0; req_wdata = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; exp_line = '0;
    @(negedge clk);
    test_reset();
    test_refill_basic();
    test_store_gnt_delay();
    test_slow_spurious();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
